mux_sel_rr_arbiter: RTL and testbench

- Upstream control stage for the 4:1 channel mux. It produces the mux's 2-bit select from four per-channel request lines.
- Arbitrates round-robin and holds a granted channel until the consumer signals done or a hold limit expires.
- Registers `sel_out` so the downstream mux sees a glitch-free, stable select for the whole grant.

---
 rtl/mux_arb_pkg.sv | 16 +
 rtl/rr_pick_4.sv | 28 ++
 rtl/mux_sel_rr_arbiter.sv | 92 +++++++++
 tb/tb_mux_sel_rr_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 4:1 mux select arbiter: channel count, select width,
// arbiter state encoding and the reset value of the round-robin pointer.
package mux_arb_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Pointer starts at the last channel so the first search begins at channel 0.
  localparam logic [SEL_W-1:0] LAST_PTR_RST = 2'b11;

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin search: first set request after ptr, wrapping,
// with the channel at ptr itself checked last.
module rr_pick_4
  import mux_arb_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              found,
  output logic [SEL_W-1:0]  idx
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest offset down to ptr+1 so the nearest requester overrides.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin arbiter driving the registered 2-bit select of the 4:1 channel mux;
// a grant is held until done, a hold-limit timeout, or the request drops.
module mux_sel_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int HOLD_MAX = 8,
  localparam int CNT_W    = $clog2(HOLD_MAX)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [NUM_CH-1:0] req_in,
  input  logic              done_in,
  output logic [SEL_W-1:0]  sel_out,
  output logic [NUM_CH-1:0] grant_out,
  output logic              valid_out
);

  arb_state_t       state_p0, state_nx;
  logic [SEL_W-1:0] sel_p0, sel_nx;
  logic [SEL_W-1:0] last_ptr_p0, last_ptr_nx;
  logic [CNT_W-1:0] hold_cnt_p0, hold_cnt_nx;
  logic             vld_p0;

  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             hold_last;
  logic             release_grant;

  rr_pick_4 u_pick (
    .req   (req_in),
    .ptr   (last_ptr_p0),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign hold_last     = (hold_cnt_p0 == CNT_W'(HOLD_MAX - 1));
  assign release_grant = done_in | hold_last | ~req_in[sel_p0];

  always_comb begin
    state_nx    = state_p0;
    sel_nx      = sel_p0;
    last_ptr_nx = last_ptr_p0;
    hold_cnt_nx = hold_cnt_p0;
    case (state_p0)
      IDLE: begin
        if (pick_found) begin
          state_nx    = GRANT;
          sel_nx      = pick_idx;
          last_ptr_nx = pick_idx;
          hold_cnt_nx = '0;
        end
      end
      GRANT: begin
        if (release_grant) begin
          // Re-arbitrate in the same edge; last_ptr equals sel, so the current
          // channel only wins again when it is the only requester.
          hold_cnt_nx = '0;
          if (pick_found) begin
            sel_nx      = pick_idx;
            last_ptr_nx = pick_idx;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          hold_cnt_nx = hold_cnt_p0 + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0: all arbiter state, cleared asynchronously
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_p0    <= IDLE;
      sel_p0      <= '0;
      last_ptr_p0 <= LAST_PTR_RST;
      hold_cnt_p0 <= '0;
    end else begin
      state_p0    <= state_nx;
      sel_p0      <= sel_nx;
      last_ptr_p0 <= last_ptr_nx;
      hold_cnt_p0 <= hold_cnt_nx;
    end
  end

  assign vld_p0    = (state_p0 == GRANT);
  assign valid_out = vld_p0;
  assign sel_out   = sel_p0;
  assign grant_out = vld_p0 ? (NUM_CH'(1) << sel_p0) : '0;

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Directed bench for mux_sel_rr_arbiter: a behavioural model checked every cycle,
// plus hand-computed select/grant expectations along the directed sequence.
module tb_mux_sel_rr_arbiter;

  localparam int HOLD_MAX = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       valid;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  mux_sel_rr_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .req_in    (req),
    .done_in   (done),
    .sel_out   (sel),
    .grant_out (grant),
    .valid_out (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the mux, who was served last, how long held.
  bit m_valid;
  int m_ch;
  int m_last;
  int m_held;

  function automatic int rr_next(input logic [3:0] r, input int last);
    for (int off = 1; off <= 4; off++)
      if (r[(last + off) % 4]) return (last + off) % 4;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_ch = 0; m_last = 3; m_held = 0;
    end else begin
      int w;
      bit rel;
      w = rr_next(req, m_last);
      if (!m_valid) begin
        if (w >= 0) begin m_valid = 1; m_ch = w; m_last = w; m_held = 0; end
      end else begin
        rel = done || (m_held == HOLD_MAX - 1) || !req[m_ch];
        if (!rel) m_held++;
        else if (w >= 0) begin m_ch = w; m_last = w; m_held = 0; end
        else begin m_valid = 0; m_held = 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_valid", 32'(valid), 32'(m_valid));
      chk("model_sel",   32'(sel),   32'(m_ch));
      chk("model_grant", 32'(grant), m_valid ? (32'd1 << m_ch) : 32'd0);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  localparam logic [4:0] TBL [0:11] = '{
    5'b1111_0, 5'b0110_0, 5'b0110_1, 5'b0001_0, 5'b1001_1, 5'b1000_0,
    5'b0000_1, 5'b0101_0, 5'b0101_0, 5'b0100_1, 5'b1110_0, 5'b0011_1
  };

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    cyc(2);
    cmp_en = 1;
    chk("rst_sel", 32'(sel), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_valid", 32'(valid), 0);
    rst_n = 1'b1;

    // Full round-robin rotation with done held high
    req = 4'b1111; done = 1'b1;
    cyc();
    chk("rr_first_valid", 32'(valid), 1);
    chk("rr_first_sel", 32'(sel), 0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("rr_seq_sel", 32'(sel), 32'(i % 4));
      chk("rr_seq_valid", 32'(valid), 1);
    end

    // Request drop on channel 0 returns to idle, select holds
    req = 4'b0000; done = 1'b0;
    cyc();
    chk("drop_valid", 32'(valid), 0);
    chk("drop_grant", 32'(grant), 0);
    chk("drop_sel", 32'(sel), 0);

    // done in IDLE with no requests changes nothing
    done = 1'b1;
    cyc(2);
    chk("idle_done_valid", 32'(valid), 0);
    chk("idle_done_sel", 32'(sel), 0);
    done = 1'b0;

    // Channel 1, then 1010 with done -> 3, then done -> 1
    req = 4'b0010;
    cyc();
    chk("ch1_sel", 32'(sel), 1);
    req = 4'b1010; done = 1'b1;
    cyc();
    chk("skip_to3_sel", 32'(sel), 3);
    cyc();
    chk("back_to1_sel", 32'(sel), 1);
    done = 1'b0;

    // Channel 2 as sole requester across two timeouts
    req = 4'b0100;
    cyc();
    chk("ch2_sel", 32'(sel), 2);
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("hold2_grant", 32'(grant), 32'b0100);
    end
    // Hold counter is at 4 now: three more cycles on ch2, then timeout hands to 3
    req = 4'b1111;
    cyc(3);
    chk("pre_timeout_sel", 32'(sel), 2);
    cyc();
    chk("timeout_sel", 32'(sel), 3);
    cyc(7);
    chk("hold3_sel", 32'(sel), 3);
    cyc();
    chk("timeout3_sel", 32'(sel), 0);

    // done coinciding with timeout is a single re-arbitration
    cyc(7);
    chk("hold0_sel", 32'(sel), 0);
    done = 1'b1;
    cyc();
    chk("done_timeout_sel", 32'(sel), 1);
    done = 1'b0;
    cyc();
    chk("single_rearb_sel", 32'(sel), 1);

    // Async reset while channel 3 is granted
    req = 4'b1000;
    cyc();
    chk("ch3_sel", 32'(sel), 3);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(valid), 0);
    chk("async_rst_sel", 32'(sel), 0);
    chk("async_rst_grant", 32'(grant), 0);
    req = 4'b1001;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_sel", 32'(sel), 0);
    chk("post_rst_valid", 32'(valid), 1);

    // Directed mix of request/done vectors, checked against the model
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++) begin
        req  = TBL[i][4:1];
        done = TBL[i][0];
        cyc();
      end
    end

    req = 4'b0000; done = 1'b0;
    cyc(2);
    chk("final_idle_valid", 32'(valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
